// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: byte/halfword/word access through byte lanes, two-cycle ERROR for illegal accesses.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states before every OKAY transfer.
`timescale 1ns/1ps
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AW    = IDX_W + 2;
  localparam int LANES = 4;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

`ifdef AHB_SLV_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam logic [3:0] WAIT_LOAD = WAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [3:0]            wait_cnt_reg, wait_cnt_next;
  logic                  legal_reg, legal_next;
  logic [AW-1:0]         addr_reg;
  logic                  write_reg;
  logic [2:0]            size_reg;
  logic [LANES-1:0]      fwd_mask_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  logic                  accept;
  logic                  ready;
  logic                  rd_en;
  logic                  mem_we;
  logic                  addr_ok;
  logic                  align_ok;
  logic                  legal_in;
  logic [LANES-1:0]      lane_mask;
  logic [IDX_W-1:0]      in_idx;
  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  unused_inputs;

  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign ready   = (state_reg == S_IDLE) || (state_reg == S_ERR2);
  assign rd_en   = ready & accept;
  assign mem_we  = (state_reg == S_IDLE) & legal_reg & write_reg;
  assign in_idx  = HADDR[AW-1:2];
  assign cur_idx = addr_reg[AW-1:2];
  assign addr_ok = {1'b0, HADDR} < MEM_BYTES;

  always_comb begin
    align_ok = 1'b0;
    case (HSIZE)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = ~HADDR[0];
      3'd2:    align_ok = (HADDR[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign legal_in = addr_ok & align_ok;

  // Little-endian lane selection from the captured size/offset.
  always_comb begin
    lane_mask = 4'b0000;
    case (size_reg)
      3'd0:    lane_mask = 4'b0001 << addr_reg[1:0];
      3'd1:    lane_mask = addr_reg[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    legal_next    = legal_reg;
    case (state_reg)
      S_WAIT: begin
        if (wait_cnt_reg <= 4'd1) begin
          state_next = S_IDLE;
        end
        if (wait_cnt_reg != 4'd0) begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      S_ERR1: begin
        state_next = S_ERR2;
      end
      default: begin
        state_next = S_IDLE;
        legal_next = 1'b0;
        if (accept) begin
          if (legal_in) begin
            legal_next = 1'b1;
            if (WAIT_LOAD != 4'd0) begin
              state_next    = S_WAIT;
              wait_cnt_next = WAIT_LOAD;
            end
          end else begin
            state_next = S_ERR1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      legal_reg    <= 1'b0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= 3'd0;
      fwd_mask_reg <= '0;
      fwd_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      legal_reg    <= legal_next;
      if (rd_en) begin
        addr_reg  <= HADDR[AW-1:0];
        write_reg <= HWRITE;
        size_reg  <= HSIZE;
        // The array read below sees the old word when a write to it lands on the same edge.
        fwd_mask_reg <= (mem_we && (cur_idx == in_idx)) ? lane_mask : '0;
        fwd_data_reg <= HWDATA;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] bank [MEM_DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge HCLK) begin
      if (mem_we && lane_mask[gi]) begin
        bank[cur_idx] <= HWDATA[8*gi +: 8];
      end
      if (rd_en) begin
        rd_byte_reg <= bank[in_idx];
      end
    end

    assign merged_word[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8] : rd_byte_reg;
  end

  assign HREADYOUT = ready;
  assign HRESP     = (state_reg == S_ERR1) || (state_reg == S_ERR2);
  assign HRDATA    = ((state_reg == S_IDLE) && legal_reg && !write_reg) ? merged_word : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave: directed protocol cases plus random traffic against a byte-array model.
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;

  localparam int MEM_BYTES = 1024;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  localparam int K_NONE = 0, K_OK = 1, K_ERR = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  assign HREADY = HREADYOUT;

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ref_mem [MEM_BYTES];
  int          p_kind = K_NONE;
  bit          p_write;
  logic [31:0] p_addr;
  logic [2:0]  p_size;
  logic [31:0] p_wd;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (a >= 32'(MEM_BYTES)) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1 && a[0]) return 1'b0;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int x;
    for (int k = 0; k < (1 << s); k++) begin
      x = int'(a[9:0]) + k;
      ref_mem[x] = d[8*(x%4) +: 8];
    end
  endtask

  // Present one address phase while completing the previous data phase.
  task automatic step(input bit sel, input logic [1:0] trans, input bit wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int n;
    int last;
    bit done;
    logic [31:0] exp_data;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HBURST = 3'd1;
    HWDATA = (p_kind == K_OK && p_write) ? p_wd : $urandom;
    last = (p_kind == K_OK) ? EXP_WAIT : ((p_kind == K_ERR) ? 1 : 0);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge HCLK);
      chk("hreadyout", 32'(HREADYOUT), 32'(n >= last));
      chk("hresp", 32'(HRESP), 32'(p_kind == K_ERR));
      if (n >= last || p_kind == K_ERR) begin
        exp_data = (p_kind == K_OK && !p_write) ? ref_word(p_addr) : 32'h0;
        chk("hrdata", HRDATA, exp_data);
      end
      if (HREADYOUT) begin
        done = 1'b1;
        if (p_kind == K_OK && !p_write) last_rdata = HRDATA;
      end else if (n >= 20) begin
        vectors++;
        miscompares++;
        $error("FAIL timeout observed=HREADYOUT low for %0d cycles expected=at most %0d", n + 1, last);
        done = 1'b1;
      end
      @(posedge HCLK);
      #1;
      n++;
    end
    if (p_kind == K_OK && p_write) ref_write(p_addr, p_size, p_wd);
    if (sel && trans[1]) p_kind = is_legal(addr, size) ? K_OK : K_ERR;
    else p_kind = K_NONE;
    p_write = wr; p_addr = addr; p_size = size; p_wd = wd;
  endtask

  task automatic idle();
    step(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=no finish expected=finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;

    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HTRANS = T_IDLE; HWDATA = '0;
    #3;
    chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("reset_hresp", 32'(HRESP), 32'd0);
    chk("reset_hrdata", HRDATA, 32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 256; i++) step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'(i * 4), $urandom);

    step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    idle();
    chk("raw_word", last_rdata, 32'hDEADBEEF);

    step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h11223344);
    step(1'b1, T_SEQ,    1'b1, 3'd0, 32'h23, 32'hAA000000);
    step(1'b1, T_SEQ,    1'b1, 3'd1, 32'h20, 32'h00005566);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    idle();
    chk("byte_lanes", last_rdata, 32'hAA225566);

    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h400, 32'h0);
    idle();
    idle();
    step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h22, 32'hFFFFFFFF);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    idle();
    chk("err_write_no_change", last_rdata, 32'hAA225566);
    step(1'b1, T_NONSEQ, 1'b0, 3'd3, 32'h0, 32'h0);
    step(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h21, 32'h0);
    idle();

    step(1'b1, T_BUSY, 1'b1, 3'd2, 32'h20, 32'h0BAD0BAD);
    step(1'b1, T_IDLE, 1'b1, 3'd2, 32'h20, 32'h0BAD0BAD);
    step(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'h0BAD0BAD);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    idle();
    chk("idle_busy_no_change", last_rdata, 32'hAA225566);

    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    chk("wait_read_first", last_rdata, 32'hDEADBEEF);
    idle();
    chk("wait_read_second", last_rdata, 32'hAA225566);

    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h400, 32'h0);
    HSEL = 1'b0; HTRANS = T_IDLE;
    #2;
    chk("err1_before_reset", 32'(HREADYOUT), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("async_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("async_rst_hresp", 32'(HRESP), 32'd0);
    chk("async_rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    p_kind = K_NONE;

    step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h30, 32'h12345678);
    HSEL = 1'b0; HTRANS = T_IDLE; HWDATA = 32'h12345678;
    #2;
    chk("wait_before_reset", 32'(HREADYOUT), (EXP_WAIT > 0) ? 32'd0 : 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("rst_wait_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_wait_hresp", 32'(HRESP), 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    p_kind = K_NONE;
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0);
    step(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h34, 32'hCAFEF00D);
    step(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h34, 32'h0);
    idle();
    chk("post_reset_pair", last_rdata, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      sel   = ($urandom_range(0, 7) != 0);
      trans = 2'($urandom_range(0, 3));
      wr    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 15))
        0:       addr = 32'($urandom_range(MEM_BYTES, MEM_BYTES + 80));
        1:       addr = 32'hFFFF_FFF0;
        2, 3, 4: addr = p_addr;
        default: addr = 32'($urandom_range(0, MEM_BYTES - 1));
      endcase
      if ($urandom_range(0, 3) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
      step(sel, trans, wr, size, addr, $urandom);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
